// File: rtl/fifo_sync_param_pkg.sv
// rtl/fifo_sync_param_pkg.sv - shared constants, width helper and status type for fifo_sync_param
package fifo_sync_param_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic almost_full;
    logic full;
    logic error;
    logic ovf_sticky;
    logic udf_sticky;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sync_param_ptr.sv
// rtl/fifo_sync_param_ptr.sv - pointer counter with enable, wrapping from DEPTH-1 to 0
module fifo_sync_param_ptr #(
  parameter int DEPTH = 16,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Explicit compare so non-power-of-two depths wrap correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - synchronous FIFO with count, thresholds and sticky errors
// FIFO_SYNC_PARAM_FWFT_EN selects first-word-fall-through reads instead of registered reads.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          data_out,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      error,
  output logic                      ovf_sticky,
  output logic                      udf_sticky
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  fifo_status_t     status_q;
  fifo_status_t     status_d;
  logic             pop_ok;
  logic             push_ok;
  logic             push_rej;
  logic             pop_rej;

  assign pop_ok   = pop && !status_q.empty;
  assign push_ok  = push && (!status_q.full || pop_ok);
  assign push_rej = push && !push_ok;
  assign pop_rej  = pop && !pop_ok;
  assign count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

  fifo_sync_param_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (push_ok),
    .ptr_o (wr_ptr)
  );

  fifo_sync_param_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (pop_ok),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  // Flags come from the next count so they always agree with count.
  always_comb begin
    status_d              = status_q;
    status_d.empty        = (count_d == '0);
    status_d.almost_empty = (count_d <= CW'(AE_THRESH));
    status_d.almost_full  = (count_d >= CW'(AF_THRESH));
    status_d.full         = (count_d == CW'(DEPTH));
    status_d.error        = push_rej || pop_rej;
    status_d.ovf_sticky   = push_rej ? 1'b1 : (err_clr ? 1'b0 : status_q.ovf_sticky);
    status_d.udf_sticky   = pop_rej  ? 1'b1 : (err_clr ? 1'b0 : status_q.udf_sticky);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q                <= '0;
      status_q.empty         <= 1'b1;
      status_q.almost_empty  <= 1'b1;
      status_q.almost_full   <= 1'b0;
      status_q.full          <= 1'b0;
      status_q.error         <= 1'b0;
      status_q.ovf_sticky    <= 1'b0;
      status_q.udf_sticky    <= 1'b0;
    end else begin
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  assign data_out = mem_q[rd_ptr];
  assign rd_valid = !status_q.empty;
`else
  logic [WIDTH-1:0] data_out_q;
  logic             rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ok;
      if (pop_ok) begin
        data_out_q <= mem_q[rd_ptr];
      end
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

  assign count        = count_q;
  assign empty        = status_q.empty;
  assign almost_empty = status_q.almost_empty;
  assign almost_full  = status_q.almost_full;
  assign full         = status_q.full;
  assign error        = status_q.error;
  assign ovf_sticky   = status_q.ovf_sticky;
  assign udf_sticky   = status_q.udf_sticky;

endmodule
